// File: rtl/core_types_pkg.sv
// Shared core sizing constants and the writeback request payload.
package core_types_pkg;

  localparam int unsigned PRF_WR_COUNT       = 7;
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT = 2;
  localparam int unsigned LOG_PR_COUNT       = 7;
  localparam int unsigned LOG_ROB_ENTRIES    = 7;
  localparam int unsigned WB_DATA_W          = 32;
  localparam int unsigned UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  // One writeback request: used for skid slot storage.
  typedef struct packed {
    logic [WB_DATA_W-1:0]       data;
    logic [LOG_PR_COUNT-1:0]    PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } prf_wb_req_t;

endpackage

// File: rtl/prf_wb_bank_rr_arb.sv
// Round-robin arbiter for one PRF bank: first requester at or after ptr,
// ascending with wrap, found by a priority encode over {req, req & ~below_ptr}.
module prf_wb_bank_rr_arb #(
  parameter int unsigned N = 7,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned IDX_W = $clog2(2 * N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [PTR_W-1:0] next_ptr_c,
  output logic             any_c
);

  logic [N-1:0]     upper_c;
  logic [2*N-1:0]   dbl_c;
  logic [IDX_W-1:0] hit_c;
  logic [PTR_W-1:0] win_c;

  // Requests at or above the pointer form the high-priority lower half.
  always_comb begin
    upper_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      upper_c[i] = req[i] & (PTR_W'(i) >= ptr);
    end
  end

  assign dbl_c = {req, upper_c};

  // Lowest set bit of the doubled vector, folded back to a requester index.
  always_comb begin
    hit_c      = '0;
    any_c      = 1'b0;
    win_c      = '0;
    grant_c    = '0;
    next_ptr_c = ptr;
    for (int j = 2 * int'(N) - 1; j >= 0; j--) begin
      if (dbl_c[j]) begin
        hit_c = IDX_W'(j);
        any_c = 1'b1;
      end
    end
    win_c = (hit_c >= IDX_W'(N)) ? PTR_W'(hit_c - IDX_W'(N)) : PTR_W'(hit_c);
    if (any_c) begin
      grant_c[win_c] = 1'b1;
      next_ptr_c     = (win_c == PTR_W'(N - 1)) ? '0 : PTR_W'(win_c + PTR_W'(1));
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: one skid slot per requestor, one round-robin grant per
// PRF bank per cycle, registered per-bank writeback bus.
module prf_wb_arbiter
  import core_types_pkg::prf_wb_req_t;
#(
  parameter int unsigned PRF_WR_COUNT       = core_types_pkg::PRF_WR_COUNT,
  parameter int unsigned PRF_BANK_COUNT     = core_types_pkg::PRF_BANK_COUNT,
  parameter int unsigned LOG_PRF_BANK_COUNT = core_types_pkg::LOG_PRF_BANK_COUNT,
  parameter int unsigned LOG_PR_COUNT       = core_types_pkg::LOG_PR_COUNT,
  parameter int unsigned LOG_ROB_ENTRIES    = core_types_pkg::LOG_ROB_ENTRIES
) (
  input  logic                                                       CLK,
  input  logic                                                       nRST,
  input  logic [PRF_WR_COUNT-1:0]                                    WB_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][31:0]                              WB_data_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                  WB_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0]               WB_ROB_index_by_wr,
  output logic [PRF_WR_COUNT-1:0]                                    WB_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                                  WB_bus_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                            WB_bus_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]             WB_bus_ROB_index_by_bank
);

  localparam int unsigned WR    = PRF_WR_COUNT;
  localparam int unsigned BANKS = PRF_BANK_COUNT;
  localparam int unsigned LB    = LOG_PRF_BANK_COUNT;
  localparam int unsigned UPR_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int unsigned PTR_W = (WR > 1) ? $clog2(WR) : 1;

  logic [WR-1:0]                       buf_valid;
  prf_wb_req_t                         buf_req [WR];
  prf_wb_req_t                         new_req_c [WR];
  logic [WR-1:0]                       accept_c;
  logic [WR-1:0]                       grant_c;

  logic [BANKS-1:0][WR-1:0]            bank_req_c;
  logic [BANKS-1:0][WR-1:0]            bank_grant_c;
  logic [BANKS-1:0][PTR_W-1:0]         rr_ptr;
  logic [BANKS-1:0][PTR_W-1:0]         rr_next_c;
  logic [BANKS-1:0]                    bank_any_c;

  logic [BANKS-1:0][31:0]              sel_data_c;
  logic [BANKS-1:0][UPR_W-1:0]         sel_upr_c;
  logic [BANKS-1:0][LOG_ROB_ENTRIES-1:0] sel_rob_c;

  // Pack incoming request fields into slot format.
  always_comb begin
    for (int i = 0; i < int'(WR); i++) begin
      new_req_c[i] = '{data:      WB_data_by_wr[i],
                       PR:        WB_PR_by_wr[i],
                       ROB_index: WB_ROB_index_by_wr[i]};
    end
  end

  // Per-bank candidate masks from buffered slots.
  always_comb begin
    bank_req_c = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      for (int i = 0; i < int'(WR); i++) begin
        bank_req_c[b][i] = buf_valid[i] & (buf_req[i].PR[LB-1:0] == LB'(b));
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < int'(BANKS); gb++) begin : g_bank
      prf_wb_bank_rr_arb #(
        .N (WR)
      ) u_arb (
        .req        (bank_req_c[gb]),
        .ptr        (rr_ptr[gb]),
        .grant_c    (bank_grant_c[gb]),
        .next_ptr_c (rr_next_c[gb]),
        .any_c      (bank_any_c[gb])
      );
    end
  endgenerate

  // A slot targets exactly one bank, so OR-ing bank grants is conflict free.
  always_comb begin
    grant_c = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      grant_c = grant_c | bank_grant_c[b];
    end
  end

  // Ready depends on slot state and same-cycle grant only, never on valid.
  assign WB_ready_by_wr = ~buf_valid | grant_c;
  assign accept_c       = WB_valid_by_wr & WB_ready_by_wr;

  // One-hot mux of the granted slot onto each bank's bus fields.
  always_comb begin
    sel_data_c = '0;
    sel_upr_c  = '0;
    sel_rob_c  = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      for (int i = 0; i < int'(WR); i++) begin
        if (bank_grant_c[b][i]) begin
          sel_data_c[b] = buf_req[i].data;
          sel_upr_c[b]  = buf_req[i].PR[LOG_PR_COUNT-1:LB];
          sel_rob_c[b]  = buf_req[i].ROB_index;
        end
      end
    end
  end

  // Skid slots: accept loads (even when granted), grant alone frees.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid <= '0;
      for (int i = 0; i < int'(WR); i++) begin
        buf_req[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WR); i++) begin
        if (accept_c[i]) begin
          buf_valid[i] <= 1'b1;
          buf_req[i]   <= new_req_c[i];
        end else if (grant_c[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointers advance past the winner, hold when idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < int'(BANKS); b++) begin
        if (bank_any_c[b]) begin
          rr_ptr[b] <= rr_next_c[b];
        end
      end
    end
  end

  // Registered writeback bus; payload fields hold when the bank is idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      WB_bus_valid_by_bank     <= '0;
      WB_bus_data_by_bank      <= '0;
      WB_bus_upper_PR_by_bank  <= '0;
      WB_bus_ROB_index_by_bank <= '0;
    end else begin
      WB_bus_valid_by_bank <= bank_any_c;
      for (int b = 0; b < int'(BANKS); b++) begin
        if (bank_any_c[b]) begin
          WB_bus_data_by_bank[b]      <= sel_data_c[b];
          WB_bus_upper_PR_by_bank[b]  <= sel_upr_c[b];
          WB_bus_ROB_index_by_bank[b] <= sel_rob_c[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter with a per-bank ordered scoreboard.
module tb_prf_wb_arbiter;

  localparam int WR    = 7;
  localparam int BANKS = 4;

  logic                  CLK;
  logic                  nRST;
  logic [WR-1:0]         wb_valid;
  logic [WR-1:0][31:0]   wb_data;
  logic [WR-1:0][6:0]    wb_pr;
  logic [WR-1:0][6:0]    wb_rob;
  logic [WR-1:0]         wb_ready;
  logic [BANKS-1:0]      bus_valid;
  logic [BANKS-1:0][31:0] bus_data;
  logic [BANKS-1:0][4:0] bus_upr;
  logic [BANKS-1:0][6:0] bus_rob;

  typedef struct {
    int          bank;
    logic [31:0] data;
    logic [4:0]  upr;
    logic [6:0]  rob;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  prf_wb_arbiter dut (
    .CLK                      (CLK),
    .nRST                     (nRST),
    .WB_valid_by_wr           (wb_valid),
    .WB_data_by_wr            (wb_data),
    .WB_PR_by_wr              (wb_pr),
    .WB_ROB_index_by_wr       (wb_rob),
    .WB_ready_by_wr           (wb_ready),
    .WB_bus_valid_by_bank     (bus_valid),
    .WB_bus_data_by_bank      (bus_data),
    .WB_bus_upper_PR_by_bank  (bus_upr),
    .WB_bus_ROB_index_by_bank (bus_rob)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int bank, input logic [31:0] d, input logic [4:0] u, input logic [6:0] r);
    exp_t e;
    e.bank = bank;
    e.data = d;
    e.upr  = u;
    e.rob  = r;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int i, input logic [6:0] pr, input logic [31:0] d, input logic [6:0] rob);
    wb_valid[i] = 1'b1;
    wb_pr[i]    = pr;
    wb_data[i]  = d;
    wb_rob[i]   = rob;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every bus writeback must match the oldest expectation for its bank.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      for (int b = 0; b < BANKS; b++) begin
        if (bus_valid[b] === 1'b1) begin
          int idx;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].bank == b) idx = k;
          end
          check($sformatf("wb_expected_b%0d", b), (idx >= 0) ? 1 : 0, 1);
          if (idx >= 0) begin
            check($sformatf("sb_data_b%0d", b), bus_data[b], exp_q[idx].data);
            check($sformatf("sb_upr_b%0d", b),  bus_upr[b],  exp_q[idx].upr);
            check($sformatf("sb_rob_b%0d", b),  bus_rob[b],  exp_q[idx].rob);
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int s0;
    int s3;
    logic r0;
    logic r3;

    nRST     = 1'b0;
    wb_valid = '0;
    wb_data  = '0;
    wb_pr    = '0;
    wb_rob   = '0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #2;
    check("rst_ready",     wb_ready,  7'h7F);
    check("rst_bus_valid", bus_valid, 4'h0);
    check("rst_bus_data",  bus_data,  128'h0);
    check("rst_bus_upr",   bus_upr,   20'h0);
    check("rst_bus_rob",   bus_rob,   28'h0);
    nRST = 1'b1;
    tick();
    check("post_rst_ready",     wb_ready,  7'h7F);
    check("post_rst_bus_valid", bus_valid, 4'h0);
    check("post_rst_bus_data",  bus_data,  128'h0);

    // Single request to bank 1.
    drive(0, 7'h05, 32'hDEADBEEF, 7'h12);
    push(1, 32'hDEADBEEF, 5'h01, 7'h12);
    check("single_ready_pre", wb_ready[0], 1'b1);
    tick();
    wb_valid = '0;
    check("single_ready_n1", wb_ready[0], 1'b1);
    check("single_bus_n1",   bus_valid,   4'b0000);
    tick();
    check("single_bus_valid", bus_valid,   4'b0010);
    check("single_bus_data",  bus_data[1], 32'hDEADBEEF);
    check("single_bus_upr",   bus_upr[1],  5'h01);
    check("single_bus_rob",   bus_rob[1],  7'h12);
    check("single_ready_n2",  wb_ready[0], 1'b1);
    tick();
    check("single_bus_idle", bus_valid, 4'b0000);

    // Three-way conflict on bank 2.
    drive(0, 7'h02, 32'hA0A0_0000, 7'h20);
    drive(1, 7'h06, 32'hA1A1_0001, 7'h21);
    drive(2, 7'h0A, 32'hA2A2_0002, 7'h22);
    push(2, 32'hA0A0_0000, 5'h00, 7'h20);
    push(2, 32'hA1A1_0001, 5'h01, 7'h21);
    push(2, 32'hA2A2_0002, 5'h02, 7'h22);
    tick();
    wb_valid = '0;
    check("conf_ready_n1", wb_ready[2:0], 3'b001);
    tick();
    check("conf_valid_n2", bus_valid,     4'b0100);
    check("conf_data_n2",  bus_data[2],   32'hA0A0_0000);
    check("conf_ready_n2", wb_ready[2:0], 3'b011);
    tick();
    check("conf_valid_n3", bus_valid,   4'b0100);
    check("conf_data_n3",  bus_data[2], 32'hA1A1_0001);
    tick();
    check("conf_valid_n4", bus_valid,   4'b0100);
    check("conf_data_n4",  bus_data[2], 32'hA2A2_0002);
    tick();
    check("conf_idle", bus_valid, 4'b0000);

    // Fairness: wr0 and wr3 hammer bank 0; grants must alternate from wr0.
    for (int k = 0; k < 6; k++) begin
      push(0, 32'hF000_0000 | 32'(k), 5'h02, 7'(k));
      if (k < 5) push(0, 32'hF300_0000 | 32'(k), 5'h03, 7'(32 + k));
    end
    s0 = 0;
    s3 = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 7'h08, 32'hF000_0000 | 32'(s0), 7'(s0));
      drive(3, 7'h0C, 32'hF300_0000 | 32'(s3), 7'(32 + s3));
      r0 = wb_ready[0];
      r3 = wb_ready[3];
      tick();
      if (r0) s0++;
      if (r3) s3++;
      if (c >= 1) check($sformatf("fair_busy_c%0d", c), bus_valid[0], 1'b1);
    end
    wb_valid = '0;
    check("fair_wr0_accepts", s0, 6);
    check("fair_wr3_accepts", s3, 5);
    tick();
    check("fair_drain1", bus_valid[0], 1'b1);
    tick();
    check("fair_drain2", bus_valid[0], 1'b1);
    tick();
    check("fair_idle", bus_valid, 4'b0000);
    check("fair_q_empty", exp_q.size(), 0);

    // Parallel banks: four requestors, four banks, one cycle.
    for (int i = 0; i < 4; i++) begin
      drive(i, 7'(8'h10 + i), 32'hB000_0000 | 32'(i), 7'(8'h30 + i));
      push(i, 32'hB000_0000 | 32'(i), 5'h04, 7'(8'h30 + i));
    end
    tick();
    wb_valid = '0;
    tick();
    check("par_valid", bus_valid, 4'b1111);
    check("par_upr",   bus_upr,   {4{5'h04}});
    check("par_rob",   bus_rob,   {7'h33, 7'h32, 7'h31, 7'h30});
    tick();
    check("par_idle",    bus_valid,    4'b0000);
    check("par_q_empty", exp_q.size(), 0);

    // Reset mid-flight: three requests on bank 3, one already on the bus.
    drive(4, 7'h03, 32'hC4C4_0004, 7'h44);
    drive(5, 7'h07, 32'hC5C5_0005, 7'h45);
    drive(6, 7'h0B, 32'hC6C6_0006, 7'h46);
    tick();
    wb_valid = '0;
    check("mid_buffered", wb_ready[6:4], 3'b001);
    tick();
    check("mid_inflight", bus_valid, 4'b1000);
    #1;
    nRST = 1'b0;
    #1;
    check("mid_rst_valid", bus_valid, 4'b0000);
    check("mid_rst_ready", wb_ready,  7'h7F);
    nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mid_post_valid_c%0d", c), bus_valid, 4'b0000);
      check($sformatf("mid_post_ready_c%0d", c), wb_ready,  7'h7F);
    end
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
